// File: rtl/round_sequencer_if.sv
// round_sequencer_if: handshake bundle between key decode, round timer and the game controller
interface round_sequencer_if;
  logic       start;
  logic       key_valid;
  logic       key_hit;
  logic       timer_cout;
  logic       gameState;
  logic       timer_init;
  logic [3:0] roundTime;
  logic       new_target;
  logic [7:0] score;
  logic [1:0] lives;
  logic [2:0] level;
  logic       game_over;
  modport master (
    output start, key_valid, key_hit, timer_cout,
    input  gameState, timer_init, roundTime, new_target, score, lives, level, game_over
  );
  modport slave (
    input  start, key_valid, key_hit, timer_cout,
    output gameState, timer_init, roundTime, new_target, score, lives, level, game_over
  );
endinterface

// File: rtl/round_sequencer.sv
// round_sequencer: arms the round timer, judges key presses against expiry, tracks score/lives/level
module round_sequencer #(
  parameter int START_TIME       = 9,
  parameter int MIN_TIME         = 3,
  parameter int LIVES            = 3,
  parameter int ROUNDS_PER_LEVEL = 4,
  parameter int GAP_CYCLES       = 8
) (
  input logic               clk,
  input logic               INIT,
  round_sequencer_if.slave  bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ARM  = 3'd1;
  localparam logic [2:0] PLAY = 3'd2;
  localparam logic [2:0] GAP  = 3'd3;
  localparam logic [2:0] OVER = 3'd4;

  logic [2:0] r_state;
  logic [3:0] r_round_cnt;
  logic [7:0] r_gap_cnt;
  logic       r_first;
  logic       r_game_state;
  logic       r_timer_init;
  logic       r_new_target;
  logic [3:0] r_round_time;
  logic [7:0] r_score;
  logic [1:0] r_lives;
  logic [2:0] r_level;
  logic       r_game_over;
  logic       w_hit;
  logic       w_miss;
  logic       w_level_up;

  assign w_hit      = bus.key_valid && bus.key_hit;
  assign w_miss     = bus.key_valid || (bus.timer_cout && !r_first);
  assign w_level_up = r_round_cnt == 4'(ROUNDS_PER_LEVEL - 1);

  // game FSM with all outputs registered; a round ends on the same edge that scores it
  always_ff @(posedge clk or posedge INIT) begin
    if (INIT) begin
      r_state      <= IDLE;
      r_round_cnt  <= '0;
      r_gap_cnt    <= '0;
      r_first      <= 1'b0;
      r_game_state <= 1'b0;
      r_timer_init <= 1'b0;
      r_new_target <= 1'b0;
      r_round_time <= 4'(START_TIME);
      r_score      <= '0;
      r_lives      <= 2'(LIVES);
      r_level      <= '0;
      r_game_over  <= 1'b0;
    end else begin
      r_timer_init <= 1'b0;
      r_new_target <= 1'b0;
      case (r_state)
        IDLE, OVER: if (bus.start) begin
          r_state      <= ARM;
          r_score      <= '0;
          r_lives      <= 2'(LIVES);
          r_level      <= '0;
          r_round_time <= 4'(START_TIME);
          r_round_cnt  <= '0;
          r_timer_init <= 1'b1;
          r_new_target <= 1'b1;
          r_game_over  <= 1'b0;
        end
        ARM: begin
          r_state      <= PLAY;
          r_game_state <= 1'b1;
          r_first      <= 1'b1;
        end
        PLAY: begin
          r_first <= 1'b0;
          if (w_hit) begin
            r_state      <= GAP;
            r_game_state <= 1'b0;
            r_gap_cnt    <= '0;
            r_score      <= (r_score == 8'hFF) ? r_score : r_score + 8'd1;
            r_round_cnt  <= w_level_up ? 4'd0 : r_round_cnt + 4'd1;
            if (w_level_up) begin
              r_level      <= (r_level == 3'd7) ? r_level : r_level + 3'd1;
              r_round_time <= (r_round_time > 4'(MIN_TIME)) ? r_round_time - 4'd1 : 4'(MIN_TIME);
            end
          end else if (w_miss) begin
            r_state      <= (r_lives == 2'd1) ? OVER : GAP;
            r_game_over  <= r_lives == 2'd1;
            r_game_state <= 1'b0;
            r_gap_cnt    <= '0;
            r_lives      <= r_lives - 2'd1;
          end
        end
        GAP: if (r_gap_cnt == 8'(GAP_CYCLES - 1)) begin
          r_state      <= ARM;
          r_timer_init <= 1'b1;
          r_new_target <= 1'b1;
        end else begin
          r_gap_cnt <= r_gap_cnt + 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gameState  = r_game_state;
  assign bus.timer_init = r_timer_init;
  assign bus.new_target = r_new_target;
  assign bus.roundTime  = r_round_time;
  assign bus.score      = r_score;
  assign bus.lives      = r_lives;
  assign bus.level      = r_level;
  assign bus.game_over  = r_game_over;
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed games checked every cycle against a hit/miss-count game model
module tb_round_sequencer;
  localparam int START = 9, MIN = 3, LIVES = 3, R = 4, GAP = 8;
  logic clk = 1'b0;
  logic INIT = 1'b1;
  int n_checks = 0;
  int n_err = 0;
  round_sequencer_if bus();
  round_sequencer #(.START_TIME(START), .MIN_TIME(MIN), .LIVES(LIVES),
                    .ROUNDS_PER_LEVEL(R), .GAP_CYCLES(GAP)) dut (.clk(clk), .INIT(INIT), .bus(bus));

  always #5 clk = ~clk;

  // model phases: 0 idle, 1 arm, 2 play, 3 gap, 4 over; outputs derived from hit and miss totals
  int m_ph = 0, m_hits = 0, m_miss = 0, m_gap = 0, m_age = 0;

  always @(posedge clk or posedge INIT) begin
    if (INIT) begin
      m_ph <= 0; m_hits <= 0; m_miss <= 0; m_gap <= 0; m_age <= 0;
    end else begin
      case (m_ph)
        0, 4: if (bus.start) begin m_hits <= 0; m_miss <= 0; m_ph <= 1; end
        1: begin m_ph <= 2; m_age <= 0; end
        2: if (bus.key_valid && bus.key_hit) begin
             m_hits <= m_hits + 1; m_ph <= 3; m_gap <= 0;
           end else if (bus.key_valid || (bus.timer_cout && m_age > 0)) begin
             m_miss <= m_miss + 1; m_ph <= (m_miss + 1 == LIVES) ? 4 : 3; m_gap <= 0;
           end else m_age <= m_age + 1;
        3: begin m_gap <= m_gap + 1; if (m_gap + 1 == GAP) m_ph <= 1; end
        default: m_ph <= 0;
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // compare every output against the model once per cycle, away from the active edge
  always @(negedge clk) begin
    int lu;
    lu = m_hits / R;
    check("gameState", int'(bus.gameState), int'(m_ph == 2));
    check("timer_init", int'(bus.timer_init), int'(m_ph == 1));
    check("new_target", int'(bus.new_target), int'(m_ph == 1));
    check("game_over", int'(bus.game_over), int'(m_ph == 4));
    check("score", int'(bus.score), (m_hits > 255) ? 255 : m_hits);
    check("lives", int'(bus.lives), LIVES - m_miss);
    check("level", int'(bus.level), (lu > 7) ? 7 : lu);
    check("roundTime", int'(bus.roundTime), (START - lu < MIN) ? MIN : START - lu);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic wait_play();
    int n;
    n = 0;
    while (!bus.gameState && n < 20) begin tick(); n++; end
    if (!bus.gameState) check("wait_play_timeout", 0, 1);
  endtask

  task automatic press(input logic hit, input logic cout);
    wait_play();
    bus.key_valid = 1'b1; bus.key_hit = hit; bus.timer_cout = cout;
    tick();
    bus.key_valid = 1'b0; bus.key_hit = 1'b0; bus.timer_cout = 1'b0;
  endtask

  task automatic timeout();
    wait_play();
    bus.timer_cout = 1'b1;
    tick();
    check("first_play_cout_ignored", int'(bus.gameState), 1);
    tick();
    bus.timer_cout = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.key_valid = 1'b0; bus.key_hit = 1'b0; bus.timer_cout = 1'b0;
    tick(); tick();
    INIT = 1'b0;
    tick();
    check("rst_lives", int'(bus.lives), 3);
    check("rst_roundTime", int'(bus.roundTime), 9);
    pulse_start();
    check("arm_timer_init", int'(bus.timer_init), 1);
    check("arm_new_target", int'(bus.new_target), 1);
    tick();
    check("play_gameState", int'(bus.gameState), 1);
    press(1'b1, 1'b0);
    pulse_start();
    press(1'b1, 1'b1);
    check("sim_hit_lives", int'(bus.lives), 3);
    check("sim_hit_score", int'(bus.score), 2);
    press(1'b1, 1'b0);
    press(1'b0, 1'b0);
    check("wrong_lives", int'(bus.lives), 2);
    press(1'b1, 1'b0);
    check("lvl1_score", int'(bus.score), 4);
    check("lvl1_level", int'(bus.level), 1);
    check("lvl1_roundTime", int'(bus.roundTime), 8);
    wait_play();
    INIT = 1'b1; #1;
    check("init_gameState", int'(bus.gameState), 0);
    check("init_score", int'(bus.score), 0);
    check("init_lives", int'(bus.lives), 3);
    check("init_level", int'(bus.level), 0);
    check("init_roundTime", int'(bus.roundTime), 9);
    tick();
    INIT = 1'b0;
    tick();
    pulse_start();
    press(1'b1, 1'b0);
    timeout();
    check("to1_lives", int'(bus.lives), 2);
    timeout();
    timeout();
    check("over_game_over", int'(bus.game_over), 1);
    check("over_lives", int'(bus.lives), 0);
    check("over_score", int'(bus.score), 1);
    tick(); tick();
    pulse_start();
    check("restart_lives", int'(bus.lives), 3);
    check("restart_score", int'(bus.score), 0);
    check("restart_roundTime", int'(bus.roundTime), 9);
    check("restart_game_over", int'(bus.game_over), 0);
    for (int i = 0; i < 28; i++) press(1'b1, 1'b0);
    check("h28_level", int'(bus.level), 7);
    check("h28_roundTime", int'(bus.roundTime), 3);
    for (int i = 28; i < 300; i++) press(1'b1, 1'b0);
    check("h300_score", int'(bus.score), 255);
    check("h300_level", int'(bus.level), 7);
    check("h300_roundTime", int'(bus.roundTime), 3);
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
